// File: rtl/hit_resolver_if.sv
// Fighter damage bus between the hitbox/animation logic and the HUD.
// Groups the frame strobe, contact inputs and health/status outputs of hit_resolver.
// With HIT_COUNT_EN defined, the bus also carries an 8-bit hit_count.
// dbg_state exposes the resolver FSM state for observation.
interface hit_resolver_if;
    logic       frame_clk;
    logic       contact;
    logic       attack_active;
    logic [7:0] damage;
    logic       restart;
    logic [7:0] health;
    logic       hit_pulse;
    logic       invuln;
    logic       ko;
    logic [1:0] dbg_state;
`ifdef HIT_COUNT_EN
    logic [7:0] hit_count;
`endif

    // Producer side: drives the stimulus and observes the status.
    modport master (
        output frame_clk, contact, attack_active, damage, restart,
`ifdef HIT_COUNT_EN
        input  hit_count,
`endif
        input  health, hit_pulse, invuln, ko, dbg_state
    );

    // Resolver side.
    modport slave (
        input  frame_clk, contact, attack_active, damage, restart,
`ifdef HIT_COUNT_EN
        output hit_count,
`endif
        output health, hit_pulse, invuln, ko, dbg_state
    );
endinterface

// File: rtl/hit_resolver.sv
// hit_resolver: turns per-frame hitbox contact into damage for one fighter.
// Contact is sampled once per frame tick. A hit subtracts damage from health, with saturation at 0.
// After each hit, INVULN_FRAMES frame ticks of invulnerability follow.
// Knockout holds until restart.
// Optional feature: define HIT_COUNT_EN to add a saturating 8-bit hit counter on the bus.
// Status outputs are decoded from the registered state and health. They carry no logic from the inputs.
module hit_resolver #(
    parameter int MAX_HEALTH    = 100,
    parameter int INVULN_FRAMES = 30
) (
    input  logic         Clk,
    input  logic         Reset_n,
    hit_resolver_if.slave bus
);
    localparam logic [7:0] LP_MAX_HEALTH = 8'(MAX_HEALTH);
    localparam logic [7:0] LP_INVULN     = 8'(INVULN_FRAMES);

    typedef enum logic [1:0] {
        S_READY  = 2'd0,
        S_HIT    = 2'd1,
        S_INVULN = 2'd2,
        S_KO     = 2'd3
    } state_t;

    state_t     r_state;
    logic [7:0] r_health;
    logic [7:0] r_frame_cnt;
    logic       r_s1, r_s2, r_s3;
    logic       w_tick;
    logic       w_contact_hit;

    // frame_clk synchronizer plus edge-detect delay flop
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= bus.frame_clk;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // One Clk-wide strobe per rising frame_clk edge
    assign w_tick        = r_s2 & ~r_s3;
    assign w_contact_hit = w_tick & bus.contact & bus.attack_active;

    // Damage FSM. Restart overrides every state.
    // A tick that arrives during S_HIT is deliberately dropped.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state     <= S_READY;
            r_health    <= LP_MAX_HEALTH;
            r_frame_cnt <= 8'd0;
        end else if (bus.restart) begin
            r_state     <= S_READY;
            r_health    <= LP_MAX_HEALTH;
            r_frame_cnt <= 8'd0;
        end else begin
            case (r_state)
                S_READY: begin
                    if (w_contact_hit) begin
                        r_state <= S_HIT;
                    end
                end
                S_HIT: begin
                    r_frame_cnt <= LP_INVULN;
                    if (bus.damage >= r_health) begin
                        r_health <= 8'd0;
                        r_state  <= S_KO;
                    end else begin
                        r_health <= r_health - bus.damage;
                        r_state  <= S_INVULN;
                    end
                end
                S_INVULN: begin
                    if (w_tick) begin
                        if (r_frame_cnt == 8'd1) begin
                            r_frame_cnt <= 8'd0;
                            r_state     <= S_READY;
                        end else begin
                            r_frame_cnt <= r_frame_cnt - 8'd1;
                        end
                    end
                end
                S_KO: begin
                    r_health <= 8'd0;
                end
                default: begin
                    r_state <= S_READY;
                end
            endcase
        end
    end

`ifdef HIT_COUNT_EN
    logic [7:0] r_hit_count;

    // Saturating count of applied hits for the current round
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_hit_count <= 8'd0;
        end else if (bus.restart) begin
            r_hit_count <= 8'd0;
        end else if (r_state == S_HIT && r_hit_count != 8'hFF) begin
            r_hit_count <= r_hit_count + 8'd1;
        end
    end

    assign bus.hit_count = r_hit_count;
`endif

    assign bus.health    = r_health;
    assign bus.hit_pulse = (r_state == S_HIT);
    assign bus.invuln    = (r_state == S_INVULN);
    assign bus.ko        = (r_state == S_KO);
    assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_hit_resolver.sv
// Self-checking bench for hit_resolver.
// Stimulus is applied one video frame at a time.
// A frame-level model (health, invulnerability frames left, knockout) predicts the status after each frame.
// It also predicts how many hit pulses the frame should produce.
module tb_hit_resolver;
    localparam int MAXH = 100;
    localparam int INV  = 30;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    hit_resolver_if bus();

    hit_resolver #(.MAX_HEALTH(MAXH), .INVULN_FRAMES(INV)) dut (
        .Clk     (clk),
        .Reset_n (rst_n),
        .bus     (bus)
    );

    // clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // frame-level reference model
    int m_health;
    int m_mode;      // 0 open to hits, 1 invulnerable, 2 knocked out
    int m_left;      // invulnerable frames remaining
    int m_hits;

    task automatic model_reset();
        m_health = MAXH;
        m_mode   = 0;
        m_left   = 0;
        m_hits   = 0;
    endtask

    task automatic model_frame(input logic c, input logic a, input int d, input logic rs,
                               output int exp_pulse);
        exp_pulse = 0;
        if (rs) begin
            m_health = MAXH;
            m_mode   = 0;
            m_left   = 0;
            m_hits   = 0;
        end
        if (m_mode == 0) begin
            if (c && a) begin
                exp_pulse = 1;
                if (m_hits < 255) m_hits = m_hits + 1;
                m_health = (d >= m_health) ? 0 : m_health - d;
                if (m_health == 0) begin
                    m_mode = 2;
                end else begin
                    m_mode = 1;
                    m_left = INV;
                end
            end
        end else if (m_mode == 1) begin
            m_left = m_left - 1;
            if (m_left == 0) m_mode = 0;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_cmp = n_cmp + 1;
        if (act != exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // drive one frame. An optional one-Clk restart precedes the frame edge.
    task automatic do_frame(input logic c, input logic a, input logic [7:0] d, input logic rs,
                            output int pulses);
        pulses = 0;
        @(negedge clk);
        bus.contact       = c;
        bus.attack_active = a;
        bus.damage        = d;
        if (rs) begin
            bus.restart = 1'b1;
            @(negedge clk);
            bus.restart = 1'b0;
        end
        bus.frame_clk = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            pulses = pulses + int'(bus.hit_pulse);
        end
        bus.frame_clk = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            pulses = pulses + int'(bus.hit_pulse);
        end
    endtask

    // one frame, compared against the model
    task automatic run_frame(input string tag, input logic c, input logic a, input logic [7:0] d,
                             input logic rs, output int pulses);
        int exp_p;
        do_frame(c, a, d, rs, pulses);
        model_frame(c, a, int'(d), rs, exp_p);
        chk({tag, ".pulses"}, pulses, exp_p);
        chk({tag, ".health"}, int'(bus.health), m_health);
        chk({tag, ".invuln"}, int'(bus.invuln), (m_mode == 1) ? 1 : 0);
        chk({tag, ".ko"}, int'(bus.ko), (m_mode == 2) ? 1 : 0);
`ifdef HIT_COUNT_EN
        chk({tag, ".hit_count"}, int'(bus.hit_count), m_hits);
`endif
    endtask

    typedef struct {
        logic       c;
        logic       a;
        logic [7:0] d;
        logic       rs;
        int         h;
        int         hit;
        int         inv;
        int         ko;
    } vec_t;

    vec_t vecs[13];

    initial begin
        int p;
        int hits;
        int first_hit;
        int second_hit;
        int waited;
        logic rc, ra, rr;
        logic [7:0] rd;

        n_cmp = 0;
        n_bad = 0;

        vecs[0]  = '{1'b1, 1'b1, 8'd10,  1'b0, 90,  1, 1, 0};
        vecs[1]  = '{1'b1, 1'b1, 8'd10,  1'b0, 90,  0, 1, 0};
        vecs[2]  = '{1'b0, 1'b0, 8'd0,   1'b1, 100, 0, 0, 0};
        vecs[3]  = '{1'b1, 1'b0, 8'd50,  1'b0, 100, 0, 0, 0};
        vecs[4]  = '{1'b0, 1'b1, 8'd50,  1'b0, 100, 0, 0, 0};
        vecs[5]  = '{1'b1, 1'b1, 8'd0,   1'b0, 100, 1, 1, 0};
        vecs[6]  = '{1'b0, 1'b0, 8'd0,   1'b1, 100, 0, 0, 0};
        vecs[7]  = '{1'b1, 1'b1, 8'd200, 1'b0, 0,   1, 0, 1};
        vecs[8]  = '{1'b1, 1'b1, 8'd10,  1'b0, 0,   0, 0, 1};
        vecs[9]  = '{1'b0, 1'b0, 8'd0,   1'b1, 100, 0, 0, 0};
        vecs[10] = '{1'b1, 1'b1, 8'd100, 1'b0, 0,   1, 0, 1};
        vecs[11] = '{1'b1, 1'b1, 8'd30,  1'b1, 70,  1, 1, 0};
        vecs[12] = '{1'b0, 1'b0, 8'd0,   1'b1, 100, 0, 0, 0};

        // reset
        rst_n             = 1'b0;
        bus.frame_clk     = 1'b0;
        bus.contact       = 1'b0;
        bus.attack_active = 1'b0;
        bus.damage        = 8'd0;
        bus.restart       = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset.health", int'(bus.health), MAXH);
        chk("reset.hit_pulse", int'(bus.hit_pulse), 0);
        chk("reset.invuln", int'(bus.invuln), 0);
        chk("reset.ko", int'(bus.ko), 0);
`ifdef HIT_COUNT_EN
        chk("reset.hit_count", int'(bus.hit_count), 0);
`endif

        // table vectors
        for (int i = 0; i < 13; i++) begin
            run_frame($sformatf("vec%0d", i), vecs[i].c, vecs[i].a, vecs[i].d, vecs[i].rs, p);
            chk($sformatf("vec%0d.tbl_health", i), int'(bus.health), vecs[i].h);
            chk($sformatf("vec%0d.tbl_pulse", i), p, vecs[i].hit);
            chk($sformatf("vec%0d.tbl_invuln", i), int'(bus.invuln), vecs[i].inv);
            chk($sformatf("vec%0d.tbl_ko", i), int'(bus.ko), vecs[i].ko);
        end

        // 40 frames of continuous contact: hits on frame 1 and frame 32 only
        hits = 0;
        first_hit = -1;
        second_hit = -1;
        for (int f = 1; f <= 40; f++) begin
            run_frame("hold40", 1'b1, 1'b1, 8'd10, (f == 1) ? 1'b1 : 1'b0, p);
            if (p != 0) begin
                hits = hits + 1;
                if (first_hit < 0) first_hit = f;
                else if (second_hit < 0) second_hit = f;
            end
        end
        chk("hold40.hits", hits, 2);
        chk("hold40.first", first_hit, 1);
        chk("hold40.second", second_hit, INV + 2);
        chk("hold40.health", int'(bus.health), 80);

        // health 5 then damage 20 saturates to 0
        run_frame("sat.a", 1'b1, 1'b1, 8'd95, 1'b1, p);
        for (int f = 0; f < INV; f++) run_frame("sat.idle", 1'b0, 1'b0, 8'd0, 1'b0, p);
        chk("sat.pre_health", int'(bus.health), 5);
        chk("sat.pre_invuln", int'(bus.invuln), 0);
        run_frame("sat.b", 1'b1, 1'b1, 8'd20, 1'b0, p);
        chk("sat.health", int'(bus.health), 0);
        chk("sat.ko", int'(bus.ko), 1);
        run_frame("sat.c", 1'b1, 1'b1, 8'd20, 1'b0, p);
        chk("sat.no_pulse", p, 0);

        // restart out of KO is visible on the very next Clk
        @(negedge clk);
        bus.restart = 1'b1;
        @(negedge clk);
        bus.restart = 1'b0;
        model_frame(1'b0, 1'b0, 0, 1'b1, p);
        chk("restart.health", int'(bus.health), MAXH);
        chk("restart.ko", int'(bus.ko), 0);
        chk("restart.invuln", int'(bus.invuln), 0);
        chk("restart.hit_pulse", int'(bus.hit_pulse), 0);
        // model_frame above consumed a frame that did not happen. Re-sync the model to a plain restart.
        model_reset();
        run_frame("restart.hit", 1'b1, 1'b1, 8'd25, 1'b0, p);
        chk("restart.hit_health", int'(bus.health), 75);

        // attack inactive for five frames
        run_frame("noatk.rs", 1'b0, 1'b0, 8'd0, 1'b1, p);
        hits = 0;
        for (int f = 0; f < 5; f++) begin
            run_frame("noatk", 1'b1, 1'b0, 8'd40, 1'b0, p);
            hits = hits + p;
        end
        chk("noatk.hits", hits, 0);
        chk("noatk.health", int'(bus.health), MAXH);

        // async reset in the middle of the HIT cycle
        @(negedge clk);
        bus.contact       = 1'b1;
        bus.attack_active = 1'b1;
        bus.damage        = 8'd60;
        bus.frame_clk     = 1'b1;
        waited = 0;
        while (bus.hit_pulse !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited = waited + 1;
        end
        chk("midhit.pulse_seen", int'(bus.hit_pulse === 1'b1), 1);
        rst_n = 1'b0;
        #1;
        chk("midhit.health", int'(bus.health), MAXH);
        chk("midhit.hit_pulse", int'(bus.hit_pulse), 0);
        chk("midhit.invuln", int'(bus.invuln), 0);
        chk("midhit.ko", int'(bus.ko), 0);
`ifdef HIT_COUNT_EN
        chk("midhit.hit_count", int'(bus.hit_count), 0);
`endif
        bus.frame_clk = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("midhit.after_health", int'(bus.health), MAXH);
        model_reset();

        // random frames against the model
        for (int f = 0; f < 300; f++) begin
            rc = ($urandom_range(0, 3) != 0);
            ra = ($urandom_range(0, 3) != 0);
            rd = 8'($urandom_range(0, 60));
            rr = ($urandom_range(0, 39) == 0);
            run_frame($sformatf("rand%0d", f), rc, ra, rd, rr, p);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
